// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants and scoreboard entry type for hazard control
package mips_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam logic [15:0] STALL_CNT_MAX = 16'hFFFF;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       ld;
    } sb_entry_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - EX/MEM/WB destination tracking shift register
module hazard_scoreboard
    import mips_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      i_advance,
    input  sb_entry_t i_new,
    output sb_entry_t o_ex,
    output sb_entry_t o_mem,
    output sb_entry_t o_wb
);

    sb_entry_t r_ex;
    sb_entry_t r_mem;
    sb_entry_t r_wb;

    // Entries only move when the memory stage lets the pipe advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex  <= '0;
            r_mem <= '0;
            r_wb  <= '0;
        end else if (i_advance) begin
            r_wb  <= r_mem;
            r_mem <= r_ex;
            r_ex  <= i_new;
        end
    end

    assign o_ex  = r_ex;
    assign o_mem = r_mem;
    assign o_wb  = r_wb;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - MIPS pipeline stall, flush and ID-branch forwarding control
module hazard_ctrl
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_use_rs,
    input  logic        id_use_rt,
    input  logic        id_is_branch,
    input  logic        id_branch_taken,
    input  logic [4:0]  id_rd,
    input  logic        id_regwrite,
    input  logic        id_memread,
    input  logic        mem_busy,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        pipe_en,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic [1:0]  fwd_rs_sel,
    output logic [1:0]  fwd_rt_sel,
    output logic [15:0] stall_cnt
);

    sb_entry_t   w_ex;
    sb_entry_t   w_mem;
    sb_entry_t   w_wb;
    sb_entry_t   w_new;
    logic        w_rs_ex, w_rs_mem, w_rs_wb;
    logic        w_rt_ex, w_rt_mem, w_rt_wb;
    logic        w_load_use;
    logic        w_branch_load;
    logic        w_stall;
    logic        w_fwd_active;
    logic [15:0] r_stall_cnt;

    function automatic logic f_match(input sb_entry_t e, input logic [4:0] src,
                                     input logic use_src, input logic valid);
        return valid && use_src && e.valid && (e.rd == src) && (e.rd != REG_ZERO);
    endfunction

    // Nearest producer wins; a load still in EX or MEM never forwards (it stalls).
    function automatic logic [1:0] f_sel(input logic active, input logic m_ex,
                                         input logic m_mem, input logic m_wb,
                                         input logic ld_ex, input logic ld_mem);
        if (!active)              return FWD_RF;
        else if (m_ex && !ld_ex)  return FWD_EX;
        else if (m_mem && !ld_mem) return FWD_MEM;
        else if (m_wb)            return FWD_WB;
        else                      return FWD_RF;
    endfunction

    hazard_scoreboard u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_advance (!mem_busy),
        .i_new     (w_new),
        .o_ex      (w_ex),
        .o_mem     (w_mem),
        .o_wb      (w_wb)
    );

    assign w_rs_ex  = f_match(w_ex,  id_rs, id_use_rs, id_valid);
    assign w_rs_mem = f_match(w_mem, id_rs, id_use_rs, id_valid);
    assign w_rs_wb  = f_match(w_wb,  id_rs, id_use_rs, id_valid);
    assign w_rt_ex  = f_match(w_ex,  id_rt, id_use_rt, id_valid);
    assign w_rt_mem = f_match(w_mem, id_rt, id_use_rt, id_valid);
    assign w_rt_wb  = f_match(w_wb,  id_rt, id_use_rt, id_valid);

    assign w_load_use    = w_ex.ld && (w_rs_ex || w_rt_ex);
    assign w_branch_load = id_is_branch && w_mem.ld && (w_rs_mem || w_rt_mem);
    assign w_stall       = w_load_use || w_branch_load;

    assign w_new.valid = id_valid && id_regwrite && !w_stall;
    assign w_new.rd    = id_rd;
    assign w_new.ld    = id_memread;

    assign w_fwd_active = id_is_branch && !w_stall;
    assign fwd_rs_sel   = f_sel(w_fwd_active, w_rs_ex, w_rs_mem, w_rs_wb, w_ex.ld, w_mem.ld);
    assign fwd_rt_sel   = f_sel(w_fwd_active, w_rt_ex, w_rt_mem, w_rt_wb, w_ex.ld, w_mem.ld);

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        pipe_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        if (rst_n) begin
            if (mem_busy) begin
                pc_en   = 1'b0;
                ifid_en = 1'b0;
                pipe_en = 1'b0;
            end else if (w_stall) begin
                pc_en       = 1'b0;
                ifid_en     = 1'b0;
                idex_bubble = 1'b1;
            end else if (id_valid && id_is_branch && id_branch_taken) begin
                ifid_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (!mem_busy && w_stall && (r_stall_cnt != STALL_CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - randomized and directed checks of hazard_ctrl against a pipeline model
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        t_valid = 1'b0;
    logic [4:0]  t_rs = '0, t_rt = '0, t_rd = '0;
    logic        t_urs = 1'b0, t_urt = 1'b0, t_br = 1'b0, t_tk = 1'b0;
    logic        t_rw = 1'b0, t_mr = 1'b0, t_busy = 1'b0;
    logic        pc_en, ifid_en, pipe_en, ifid_flush, idex_bubble;
    logic [1:0]  fwd_rs_sel, fwd_rt_sel;
    logic [15:0] stall_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // Model of the three downstream stages, index 0=EX, 1=MEM, 2=WB.
    bit         m_v  [3];
    logic [4:0] m_rd [3];
    bit         m_ld [3];
    int         m_cnt;
    bit         m_stall;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_valid        (t_valid),
        .id_rs           (t_rs),
        .id_rt           (t_rt),
        .id_use_rs       (t_urs),
        .id_use_rt       (t_urt),
        .id_is_branch    (t_br),
        .id_branch_taken (t_tk),
        .id_rd           (t_rd),
        .id_regwrite     (t_rw),
        .id_memread      (t_mr),
        .mem_busy        (t_busy),
        .pc_en           (pc_en),
        .ifid_en         (ifid_en),
        .pipe_en         (pipe_en),
        .ifid_flush      (ifid_flush),
        .idex_bubble     (idex_bubble),
        .fwd_rs_sel      (fwd_rs_sel),
        .fwd_rt_sel      (fwd_rt_sel),
        .stall_cnt       (stall_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit m_hit(input int i, input logic [4:0] s, input logic u);
        return t_valid && u && m_v[i] && (m_rd[i] == s) && (s != 5'd0);
    endfunction

    function automatic int m_sel(input logic [4:0] s, input logic u, input bit st);
        if (!t_br || st) return 0;
        if (m_hit(0, s, u) && !m_ld[0]) return 1;
        if (m_hit(1, s, u) && !m_ld[1]) return 2;
        if (m_hit(2, s, u)) return 3;
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_v[i] = 0; m_rd[i] = '0; m_ld[i] = 0;
        end
        m_cnt = 0;
    endtask

    task automatic check_outputs();
        bit st = 0;
        int e_pc = 1, e_if = 1, e_pipe = 1, e_fl = 0, e_bub = 0, e_rs = 0, e_rt = 0;
        if (rst_n) begin
            st = (m_ld[0] && (m_hit(0, t_rs, t_urs) || m_hit(0, t_rt, t_urt))) ||
                 (t_br && m_ld[1] && (m_hit(1, t_rs, t_urs) || m_hit(1, t_rt, t_urt)));
            if (t_busy) begin
                e_pc = 0; e_if = 0; e_pipe = 0;
            end else if (st) begin
                e_pc = 0; e_if = 0; e_bub = 1;
            end else begin
                e_fl = (t_valid && t_br && t_tk) ? 1 : 0;
            end
            e_rs = m_sel(t_rs, t_urs, st);
            e_rt = m_sel(t_rt, t_urt, st);
        end
        m_stall = st;
        check_eq("pc_en",       32'(pc_en),       32'(e_pc));
        check_eq("ifid_en",     32'(ifid_en),     32'(e_if));
        check_eq("pipe_en",     32'(pipe_en),     32'(e_pipe));
        check_eq("ifid_flush",  32'(ifid_flush),  32'(e_fl));
        check_eq("idex_bubble", 32'(idex_bubble), 32'(e_bub));
        check_eq("fwd_rs_sel",  32'(fwd_rs_sel),  32'(e_rs));
        check_eq("fwd_rt_sel",  32'(fwd_rt_sel),  32'(e_rt));
        check_eq("stall_cnt",   32'(stall_cnt),   32'(m_cnt));
    endtask

    // Called at a falling edge: checks this cycle, then applies the coming rising edge to the model.
    task automatic step();
        #1;
        check_outputs();
        if (rst_n && !t_busy) begin
            for (int i = 2; i > 0; i--) begin
                m_v[i] = m_v[i-1]; m_rd[i] = m_rd[i-1]; m_ld[i] = m_ld[i-1];
            end
            m_v[0]  = t_valid && t_rw && !m_stall;
            m_rd[0] = t_rd;
            m_ld[0] = t_mr;
            if (m_stall && m_cnt < 65535) m_cnt++;
        end
        @(negedge clk);
    endtask

    task automatic issue(input logic v, input logic [4:0] rs, input logic urs,
                         input logic [4:0] rt, input logic urt, input logic br,
                         input logic tk, input logic [4:0] rd, input logic rw,
                         input logic mr, input logic busy);
        t_valid = v; t_rs = rs; t_urs = urs; t_rt = rt; t_urt = urt; t_br = br;
        t_tk = tk; t_rd = rd; t_rw = rw; t_mr = mr; t_busy = busy;
        step();
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // LW $3 ; ADD $4,$3,$5 : one bubble then issue
        issue(1, 0, 0, 0, 0, 0, 0, 3, 1, 1, 0);
        issue(1, 3, 1, 5, 1, 0, 0, 4, 1, 0, 0);
        check_eq("lu_cnt", 32'(stall_cnt), 32'd1);
        issue(1, 3, 1, 5, 1, 0, 0, 4, 1, 0, 0);
        pulse_reset();

        // LW $3 ; BEQ $3,$0 taken : two stalls, then WB forward and flush
        issue(1, 0, 0, 0, 0, 0, 0, 3, 1, 1, 0);
        issue(1, 3, 1, 0, 1, 1, 1, 0, 0, 0, 0);
        issue(1, 3, 1, 0, 1, 1, 1, 0, 0, 0, 0);
        check_eq("bl_cnt", 32'(stall_cnt), 32'd2);
        check_eq("bl_sel", 32'(fwd_rs_sel), 32'd3);
        issue(1, 3, 1, 0, 1, 1, 1, 0, 0, 0, 0);
        pulse_reset();

        // ADD $7 ; BEQ $7,$7 and ADD $7 ; NOP ; BEQ $7
        issue(1, 1, 1, 2, 1, 0, 0, 7, 1, 0, 0);
        check_eq("ex_fwd_pre", 32'(fwd_rs_sel), 32'd0);
        issue(1, 7, 1, 7, 1, 1, 0, 0, 0, 0, 0);
        issue(1, 1, 1, 2, 1, 0, 0, 7, 1, 0, 0);
        issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        issue(1, 7, 1, 7, 1, 1, 1, 0, 0, 0, 0);

        // LW $0 ; ADD $4,$0,$0 : register zero never hazards
        issue(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        issue(1, 0, 1, 0, 1, 0, 0, 4, 1, 0, 0);

        // Load-use stall frozen by three busy cycles, then a mid-stall reset
        issue(1, 0, 0, 0, 0, 0, 0, 3, 1, 1, 0);
        for (int i = 0; i < 3; i++) issue(1, 3, 1, 5, 1, 0, 0, 4, 1, 0, 1);
        issue(1, 3, 1, 5, 1, 0, 0, 4, 1, 0, 0);
        issue(1, 3, 1, 5, 1, 0, 0, 4, 1, 0, 0);
        issue(1, 0, 0, 0, 0, 0, 0, 3, 1, 1, 0);
        issue(1, 3, 1, 0, 1, 1, 1, 0, 0, 0, 0);
        pulse_reset();
        issue(1, 3, 1, 0, 1, 1, 1, 0, 0, 0, 0);

        // Randomized traffic with a narrow register range to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) pulse_reset();
            issue(($urandom_range(0, 99) < 85) ? 1'b1 : 1'b0,
                  5'($urandom_range(0, 3)), 1'($urandom),
                  5'($urandom_range(0, 3)), 1'($urandom),
                  ($urandom_range(0, 99) < 35) ? 1'b1 : 1'b0, 1'($urandom),
                  5'($urandom_range(0, 3)), 1'($urandom),
                  ($urandom_range(0, 99) < 40) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 99) < 15) ? 1'b1 : 1'b0);
        end

        // Saturation: preload near the top, then keep stalling past 0xFFFF
        pulse_reset();
        force dut.r_stall_cnt = 16'hFFFD;
        #1;
        release dut.r_stall_cnt;
        m_cnt = 65533;
        for (int k = 0; k < 4; k++) begin
            issue(1, 0, 0, 0, 0, 0, 0, 3, 1, 1, 0);
            issue(1, 3, 1, 0, 1, 1, 0, 0, 0, 0, 0);
            issue(1, 3, 1, 0, 1, 1, 0, 0, 0, 0, 0);
        end
        check_eq("sat_cnt", 32'(stall_cnt), 32'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
